// File: rtl/cdf_writeback_if.sv
// Fetch-to-writeback handshake bundle: bin value/address in, tagged memory write out.
// The slave side is the writeback stage; the master side feeds it and plays the memory.
interface cdf_writeback_if #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 16
);
  logic              start_in;
  logic [DATA_W-1:0] accum_in;
  logic [ADDR_W-1:0] store_addr;
  logic              write_ready;
  logic              write_enable;
  logic [ADDR_W-1:0] write_addr;
  logic [127:0]      write_bus;

  modport master (
    output start_in, accum_in, store_addr, write_ready,
    input  write_enable, write_addr, write_bus
  );

  modport slave (
    input  start_in, accum_in, store_addr, write_ready,
    output write_enable, write_addr, write_bus
  );
endinterface

// File: rtl/cdf_writeback.sv
// Saturating running-sum (CDF) writeback: one tagged 128-bit write per bin, head valid the cycle after push.
// A small write FIFO absorbs WriteReady backpressure; pushes into a full FIFO without a same-cycle pop are dropped.
module cdf_writeback #(
  parameter int          DATA_W     = 20,
  parameter int          ADDR_W     = 16,
  parameter int          BINS       = 256,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] TAG        = 16'hAAAA
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  cdf_writeback_if.slave     bus,
  output logic               o_done,
  output logic               o_overflow,
  output logic               o_saturated
);
  localparam int CNT_W = $clog2(BINS) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int PAD_W = 128 - 16 - DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_sum;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_wr, r_rd;
  logic [LVL_W-1:0]  r_level, w_level_nxt;
  logic              r_overflow, r_saturated;
  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_dat  [FIFO_DEPTH];

  logic              w_active, w_we, w_pop, w_take, w_full, w_push, w_drop, w_flush, w_clip, w_last;
  logic [DATA_W:0]   w_sum_wide;
  logic [DATA_W-1:0] w_sum_nxt;

  always_comb begin
    w_active   = (r_state == S_ACCUM) || (r_state == S_DRAIN);
    w_we       = w_active && (r_level != '0);
    w_pop      = w_we && bus.write_ready;
    w_flush    = w_active && !i_start;
    // An aborting cycle ignores the fetch stage entirely.
    w_take     = (r_state == S_ACCUM) && i_start && bus.start_in;
    w_sum_wide = {1'b0, r_sum} + {1'b0, bus.accum_in};
    w_clip     = w_sum_wide[DATA_W];
    w_sum_nxt  = w_clip ? {DATA_W{1'b1}} : w_sum_wide[DATA_W-1:0];
    w_full     = (r_level == LVL_W'(FIFO_DEPTH));
    w_push     = w_take && (!w_full || w_pop);
    w_drop     = w_take && w_full && !w_pop;
    w_last     = (r_count == CNT_W'(BINS - 1));

    w_level_nxt = r_level;
    if (w_push && !w_pop)
      w_level_nxt = r_level + LVL_W'(1);
    else if (!w_push && w_pop)
      w_level_nxt = r_level - LVL_W'(1);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_ACCUM;
      S_ACCUM: begin
        if (!i_start)
          w_state_nxt = S_IDLE;
        else if (w_take && w_last)
          w_state_nxt = S_DRAIN;
      end
      // Look at the post-pop level so Done follows the final pop edge directly.
      S_DRAIN: begin
        if (!i_start)
          w_state_nxt = S_IDLE;
        else if (w_level_nxt == '0)
          w_state_nxt = S_DONE;
      end
      S_DONE:  if (!i_start) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_sum       <= '0;
      r_count     <= '0;
      r_wr        <= '0;
      r_rd        <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_saturated <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == S_IDLE) begin
        r_sum   <= '0;
        r_count <= '0;
      end else if (w_take) begin
        r_sum   <= w_sum_nxt;
        r_count <= r_count + CNT_W'(1);
      end

      if (r_state == S_IDLE || w_flush) begin
        r_wr    <= '0;
        r_rd    <= '0;
        r_level <= '0;
      end else begin
        if (w_push) r_wr <= r_wr + PTR_W'(1);
        if (w_pop)  r_rd <= r_rd + PTR_W'(1);
        r_level <= w_level_nxt;
      end

      if (r_state == S_IDLE && i_start) begin
        r_overflow  <= 1'b0;
        r_saturated <= 1'b0;
      end else begin
        if (w_drop)           r_overflow  <= 1'b1;
        if (w_take && w_clip) r_saturated <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr] <= bus.store_addr;
      r_fifo_dat[r_wr]  <= w_sum_nxt;
    end
  end

  // Gating by write_enable keeps stale FIFO contents off the bus after reset or flush.
  assign bus.write_enable = w_we;
  assign bus.write_addr   = w_we ? r_fifo_addr[r_rd] : '0;
  assign bus.write_bus    = w_we ? {{PAD_W{1'b0}}, TAG, r_fifo_dat[r_rd]} : '0;
  assign o_done           = (r_state == S_DONE);
  assign o_overflow       = r_overflow;
  assign o_saturated      = r_saturated;
endmodule

// File: tb/tb_cdf_writeback.sv
// Scoreboard bench for cdf_writeback: a queue of expected writes stands in for the write FIFO.
module tb_cdf_writeback;
  typedef enum int {M_IDLE, M_ACCUM, M_DRAIN, M_DONE} mstate_t;
  typedef struct {
    logic [15:0] addr;
    logic [19:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic done, ovf, sat;

  cdf_writeback_if #(.DATA_W(20), .ADDR_W(16)) wb_if ();

  cdf_writeback u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .bus         (wb_if),
    .o_done      (done),
    .o_overflow  (ovf),
    .o_saturated (sat)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_wr  = 0;
  ent_t        q[$];
  logic [19:0] wlog[$];
  mstate_t     m_state = M_IDLE;
  logic [19:0] m_sum = '0;
  int          m_count = 0;
  logic        m_ovf = 1'b0;
  logic        m_sat = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [19:0] acc, input logic [15:0] addr, input logic rdy);
    wb_if.start_in    = vld;
    wb_if.accum_in    = acc;
    wb_if.store_addr  = addr;
    wb_if.write_ready = rdy;
  endtask

  // Check the present cycle against the model, then advance the model across the next edge.
  task automatic cycle();
    logic        m_we, pop;
    logic [20:0] wide;
    ent_t        e;
    m_we = (m_state == M_ACCUM || m_state == M_DRAIN) && q.size() > 0;
    chk("write_enable", {127'b0, wb_if.write_enable}, {127'b0, m_we});
    if (m_we) begin
      chk("write_addr", {112'b0, wb_if.write_addr}, {112'b0, q[0].addr});
      chk("write_bus", wb_if.write_bus, {92'b0, 16'hAAAA, q[0].data});
    end
    chk("done", {127'b0, done}, {127'b0, m_state == M_DONE});
    chk("overflow", {127'b0, ovf}, {127'b0, m_ovf});
    chk("saturated", {127'b0, sat}, {127'b0, m_sat});
    if (wb_if.write_enable && wb_if.write_ready) begin
      n_wr++;
      wlog.push_back(wb_if.write_bus[19:0]);
    end
    pop = m_we && wb_if.write_ready;
    case (m_state)
      M_IDLE: if (start) begin
        m_ovf = 1'b0; m_sat = 1'b0; m_sum = '0; m_count = 0; m_state = M_ACCUM;
      end
      M_ACCUM: begin
        if (!start) begin
          q.delete(); m_state = M_IDLE;
        end else begin
          if (pop) void'(q.pop_front());
          if (wb_if.start_in) begin
            wide = {1'b0, m_sum} + {1'b0, wb_if.accum_in};
            if (wide > 21'h0FFFFF) begin
              m_sum = 20'hFFFFF; m_sat = 1'b1;
            end else begin
              m_sum = wide[19:0];
            end
            e.addr = wb_if.store_addr;
            e.data = m_sum;
            if (q.size() < 4) q.push_back(e);
            else m_ovf = 1'b1;
            m_count++;
            if (m_count == 256) m_state = M_DRAIN;
          end
        end
      end
      M_DRAIN: begin
        if (!start) begin
          q.delete(); m_state = M_IDLE;
        end else begin
          if (pop) void'(q.pop_front());
          if (q.size() == 0) m_state = M_DONE;
        end
      end
      M_DONE: if (!start) m_state = M_IDLE;
      default: m_state = M_IDLE;
    endcase
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic abort_frame();
    drive(1'b0, '0, '0, 1'b1);
    start = 1'b0;
    cycle();
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, '0, '0, 1'b1);
    repeat (2) @(negedge clk);
    chk("rst_we", {127'b0, wb_if.write_enable}, 128'd0);
    chk("rst_addr", {112'b0, wb_if.write_addr}, 128'd0);
    chk("rst_bus", wb_if.write_bus, 128'd0);
    chk("rst_done", {127'b0, done}, 128'd0);
    chk("rst_flags", {126'b0, ovf, sat}, 128'd0);
    rst = 1'b0;
    cycle();

    // Basic frame: 256 unit bins, address k carries k+1.
    start = 1'b1;
    cycle();
    n_wr = 0;
    wlog.delete();
    for (int k = 0; k < 256; k++) begin
      drive(1'b1, 20'd1, 16'(k), 1'b1);
      cycle();
    end
    drive(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 10 && m_state != M_DONE; i++) cycle();
    chk("basic_done", {127'b0, done}, 128'd1);
    chk("basic_nwrites", 128'(n_wr), 128'd256);
    chk("basic_last_data", {108'b0, wlog[$]}, 128'd256);
    chk("basic_flags", {126'b0, ovf, sat}, 128'd0);
    cycle();
    start = 1'b0;
    cycle();
    chk("done_release", {127'b0, done}, 128'd0);
    cycle();

    // Backpressure: six bins against a stalled memory, then release.
    start = 1'b1;
    cycle();
    wlog.delete();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 20'd2, 16'(k), 1'b0);
      cycle();
    end
    for (int k = 6; k < 10; k++) begin
      drive(1'b1, 20'd2, 16'(k), 1'b1);
      cycle();
    end
    drive(1'b0, '0, '0, 1'b1);
    repeat (6) cycle();
    chk("bp_overflow", {127'b0, ovf}, 128'd1);
    chk("bp_first", {108'b0, wlog[0]}, 128'd2);
    chk("bp_fifth", {108'b0, wlog[4]}, 128'd14);
    abort_frame();

    // Full FIFO with a simultaneous pop: the push must land.
    start = 1'b1;
    cycle();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 20'd3, 16'(k), 1'b0);
      cycle();
    end
    for (int k = 4; k < 7; k++) begin
      drive(1'b1, 20'd3, 16'(k), 1'b1);
      cycle();
    end
    drive(1'b0, '0, '0, 1'b1);
    repeat (6) cycle();
    chk("fullpop_overflow", {127'b0, ovf}, 128'd0);
    abort_frame();

    // Saturation at the top of the 20-bit range.
    start = 1'b1;
    cycle();
    wlog.delete();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 20'h80000, 16'(k), 1'b1);
      cycle();
    end
    drive(1'b0, '0, '0, 1'b1);
    repeat (3) cycle();
    chk("sat_d0", {108'b0, wlog[0]}, 128'h80000);
    chk("sat_d1", {108'b0, wlog[1]}, 128'hFFFFF);
    chk("sat_d2", {108'b0, wlog[2]}, 128'hFFFFF);
    chk("sat_flag", {127'b0, sat}, 128'd1);
    abort_frame();
    chk("sat_sticky_idle", {127'b0, sat}, 128'd1);

    // Abort with a stalled memory, then a fresh frame restarts the sum.
    start = 1'b1;
    cycle();
    chk("sat_cleared", {127'b0, sat}, 128'd0);
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 20'd5, 16'(k), 1'b0);
      cycle();
    end
    start = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    cycle();
    chk("abort_we", {127'b0, wb_if.write_enable}, 128'd0);
    chk("abort_ovf_sticky", {127'b0, ovf}, 128'd1);
    cycle();
    start = 1'b1;
    cycle();
    wlog.delete();
    drive(1'b1, 20'd7, 16'h0040, 1'b1);
    cycle();
    drive(1'b0, '0, '0, 1'b1);
    repeat (2) cycle();
    chk("abort_restart_n", 128'(wlog.size()), 128'd1);
    if (wlog.size() > 0) chk("abort_restart_data", {108'b0, wlog[0]}, 128'd7);
    abort_frame();

    // Asynchronous reset mid-frame with data queued and both flags set.
    start = 1'b1;
    cycle();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 20'hFFFFF, 16'(k), 1'b0);
      cycle();
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_we", {127'b0, wb_if.write_enable}, 128'd0);
    chk("arst_addr", {112'b0, wb_if.write_addr}, 128'd0);
    chk("arst_bus", wb_if.write_bus, 128'd0);
    chk("arst_flags", {125'b0, done, ovf, sat}, 128'd0);
    start = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    q.delete();
    m_state = M_IDLE;
    m_ovf = 1'b0;
    m_sat = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cdf_writeback.md
# cdf_writeback

Write-back stage at the tail of the CDF pipeline: the store-side counterpart of the fetch stage. It takes the per-bin histogram values and store addresses emitted by the fetch stage, forms a saturating running sum (the CDF), and writes one tagged 128-bit word per bin back to memory. A 4-entry FIFO with a ready handshake absorbs memory backpressure.

## Interface
- DATA_W, 20: width of bin value and CDF word
- ADDR_W, 16: memory address width
- BINS, 256: entries per frame
- FIFO_DEPTH, 4: write buffer depth, power of two
- TAG, 16'hAAAA: valid tag placed in WriteBus[35:20]
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  frame enable; held high for the whole frame
- StartIn  in  1  fetch-stage valid; AccumIn/StoreAddress are meaningful this cycle
- AccumIn  in  DATA_W  bin value
- StoreAddress  in  ADDR_W  destination address for this bin
- WriteReady  in  1  memory accepts the current write
- WriteEnable  out  1  write request valid
- WriteAddress  out  ADDR_W  write address
- WriteBus  out  128  {92'b0, TAG, cdf[19:0]}; bits [127:36] are zero
- Done  out  1  frame complete, all writes accepted
- Overflow  out  1  sticky: an entry was dropped due to a full FIFO
- Saturated  out  1  sticky: running sum clipped at all-ones

## Operation
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE: sum=0, count=0, FIFO empty. If start=1, clear Overflow and Saturated, then go to ACCUM.
- ACCUM: on each cycle with StartIn=1:
  - sum_next = min(sum + AccumIn, 2^DATA_W-1); compute the add at DATA_W+1 bits and set Saturated if clipped.
  - Push {StoreAddress, sum_next}.
  - count++.
  - When an accepted entry makes count==BINS, go to DRAIN. StartIn in DRAIN/DONE is ignored.
- FIFO push when full:
  - If a pop occurs in the same cycle, the push is accepted.
  - Otherwise the entry is dropped and Overflow is set. sum and count still update.
- Output side:
  - WriteEnable = FIFO non-empty, in ACCUM or DRAIN only.
  - WriteAddress and WriteBus come from the FIFO head.
  - Pop when WriteEnable & WriteReady.
  - Outputs hold stable while WriteEnable=1 and WriteReady=0.
- DRAIN: go to DONE when the FIFO is empty.
- DONE: Done=1, WriteEnable=0. Stays here while start=1. start=0 → IDLE.
- Abort: start=0 in ACCUM or DRAIN goes to IDLE next cycle. The FIFO is flushed; no further WriteEnable. Sticky flags hold until the next start.

## Timing
- Reset values: WriteEnable=0, WriteAddress=0, WriteBus=0, Done=0, Overflow=0, Saturated=0, state IDLE.
- start rises at edge N → ACCUM from N+1. StartIn is sampled from the first ACCUM cycle.
- Latency: StartIn at edge N with FIFO empty → WriteEnable=1 with that entry after edge N, visible in cycle N+1.
- Throughput is 1 write/cycle with WriteReady held high; the FIFO never exceeds 1 entry.
- Done asserts the cycle after the edge that pops the last entry. Done deasserts the cycle after start falls.
- Reset mid-frame: all state returns to reset values immediately. No partial write is held.

## Test plan
- Basic frame:
  - Stimulus: start=1, 256 StartIn pulses with AccumIn=1 and StoreAddress=0..255, WriteReady=1.
  - Response: 256 writes; address k carries WriteBus[19:0]=k+1 and WriteBus[35:20]=16'hAAAA. Done=1; Overflow=0 and Saturated=0.
- Backpressure:
  - Stimulus: WriteReady=0 for 6 cycles during continuous StartIn with AccumIn=2.
  - Response: first 4 entries buffered, entries 5 and 6 dropped, Overflow=1. Head (addr 0, data 2) holds stable. Write order and values after WriteReady=1 are unchanged.
- Full + simultaneous pop:
  - Stimulus: FIFO holds 4 entries, WriteReady=1 and StartIn=1 in the same cycle.
  - Response: push accepted, Overflow stays 0.
- Saturation:
  - Stimulus: AccumIn=20'h80000 for bins 0..2.
  - Response: data 80000, FFFFF, FFFFF; Saturated=1.
- Abort:
  - Stimulus: start=0 after 10 bins with WriteReady=0.
  - Response: FIFO flushed, WriteEnable=0 next cycle, IDLE. A new start begins with sum=0.
- Reset mid-frame:
  - Stimulus: assert reset asynchronously mid-frame.
  - Response: all outputs 0 without waiting for a clock edge.
